// File: rtl/lane_degrade_ctrl_if.sv
// Handshake bundle between MBTRAIN / repair exchange and the lane degrade controller.
// Signal names keep the i_/o_ prefixes as seen from the controller.
interface lane_degrade_ctrl_if;
    logic        i_en;
    logic [15:0] i_lane_result;
    logic        i_test_ack;
    logic        i_remote_first_8;
    logic        i_remote_second_8;
    logic        o_repair_en;
    logic        o_first_8_lanes_are_functional;
    logic        o_second_8_lanes_are_functional;
    logic [1:0]  o_width_mode;
    logic [15:0] o_lane_mask;
    logic        o_done;
    logic        o_error;

    // Side that drives the controller (training sequencer / partner exchange)
    modport master (
        output i_en,
        output i_lane_result,
        output i_test_ack,
        output i_remote_first_8,
        output i_remote_second_8,
        input  o_repair_en,
        input  o_first_8_lanes_are_functional,
        input  o_second_8_lanes_are_functional,
        input  o_width_mode,
        input  o_lane_mask,
        input  o_done,
        input  o_error
    );

    // The controller itself
    modport slave (
        input  i_en,
        input  i_lane_result,
        input  i_test_ack,
        input  i_remote_first_8,
        input  i_remote_second_8,
        output o_repair_en,
        output o_first_8_lanes_are_functional,
        output o_second_8_lanes_are_functional,
        output o_width_mode,
        output o_lane_mask,
        output o_done,
        output o_error
    );
endinterface

// File: rtl/lane_degrade_ctrl.sv
// Lane repair / width degrade controller.
// Latches the local per-half pass result, runs the repair exchange with a
// timeout, combines local and remote results and selects x16 / x8 / fail.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | outputs cleared, waiting for i_en (after i_en seen low here)
// RUN   | o_repair_en high, waiting for i_test_ack or timeout
// EVAL  | one cycle: combine local and remote halves
// DONE  | usable width found, o_done held until i_en drops
// ERROR | no usable half or timeout, o_done/o_error held until i_en drops
module lane_degrade_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000
) (
    input logic                clk,
    input logic                rst_n,
    lane_degrade_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    // Last RUN cycle count before the exchange is declared timed out.
    localparam logic [15:0] CNT_LAST = TIMEOUT_CYCLES - 16'd1;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic        first_q, first_d;
    logic        second_q, second_d;
    logic        rem_first_q, rem_first_d;
    logic        rem_second_q, rem_second_d;
    logic        repair_en_q, repair_en_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  width_q, width_d;
    logic [15:0] mask_q, mask_d;

    logic        agreed_first;
    logic        agreed_second;

    // A half is usable only if both link partners agree it passed.
    always_comb begin
        agreed_first  = first_q  & rem_first_q;
        agreed_second = second_q & rem_second_q;
    end

    // Next-state decode; dropping i_en always wins and aborts back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_en && armed_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.i_en) begin
                    state_d = S_IDLE;
                end else if (bus.i_test_ack) begin
                    state_d = S_EVAL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_EVAL: begin
                if (!bus.i_en) begin
                    state_d = S_IDLE;
                end else if (agreed_first || agreed_second) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (!bus.i_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RUN-cycle counter: zero outside RUN, saturating increment inside it.
    always_comb begin
        cnt_d = 16'd0;
        if (state_q == S_RUN && state_d == S_RUN) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
    end

    // Start qualifier: i_en must be seen low while idle before a new run.
    always_comb begin
        armed_d = 1'b0;
        if (state_q == S_IDLE && state_d == S_IDLE) begin
            armed_d = armed_q | ~bus.i_en;
        end
    end

    // Local and remote half results; captured once per run, cleared in IDLE.
    always_comb begin
        first_d      = first_q;
        second_d     = second_q;
        rem_first_d  = rem_first_q;
        rem_second_d = rem_second_q;
        if (state_d == S_IDLE) begin
            first_d      = 1'b0;
            second_d     = 1'b0;
            rem_first_d  = 1'b0;
            rem_second_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            first_d  = &bus.i_lane_result[7:0];
            second_d = &bus.i_lane_result[15:8];
        end else if (state_q == S_RUN && state_d == S_EVAL) begin
            rem_first_d  = bus.i_remote_first_8;
            rem_second_d = bus.i_remote_second_8;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_comb begin
        repair_en_d = (state_d == S_RUN);
        done_d      = (state_d == S_DONE) || (state_d == S_ERROR);
        error_d     = (state_d == S_ERROR);
        width_d     = width_q;
        mask_d      = mask_q;
        if (state_d == S_IDLE) begin
            width_d = 2'b00;
            mask_d  = 16'h0000;
        end else if (state_q == S_EVAL) begin
            case ({agreed_second, agreed_first})
                2'b11:   begin width_d = 2'b00; mask_d = 16'hFFFF; end
                2'b01:   begin width_d = 2'b01; mask_d = 16'h00FF; end
                2'b10:   begin width_d = 2'b10; mask_d = 16'hFF00; end
                default: begin width_d = 2'b11; mask_d = 16'h0000; end
            endcase
        end else if (state_d == S_ERROR) begin
            width_d = 2'b11;
            mask_d  = 16'h0000;
        end
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            armed_q      <= 1'b0;
            first_q      <= 1'b0;
            second_q     <= 1'b0;
            rem_first_q  <= 1'b0;
            rem_second_q <= 1'b0;
            repair_en_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            width_q      <= 2'b00;
            mask_q       <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            first_q      <= first_d;
            second_q     <= second_d;
            rem_first_q  <= rem_first_d;
            rem_second_q <= rem_second_d;
            repair_en_q  <= repair_en_d;
            done_q       <= done_d;
            error_q      <= error_d;
            width_q      <= width_d;
            mask_q       <= mask_d;
        end
    end

    assign bus.o_repair_en                     = repair_en_q;
    assign bus.o_first_8_lanes_are_functional  = first_q;
    assign bus.o_second_8_lanes_are_functional = second_q;
    assign bus.o_width_mode                    = width_q;
    assign bus.o_lane_mask                     = mask_q;
    assign bus.o_done                          = done_q;
    assign bus.o_error                         = error_q;

endmodule

// File: tb/tb_lane_degrade_ctrl.sv
// Testbench for lane_degrade_ctrl: directed scenarios plus randomized runs
// checked against a result-level reference model.
module tb_lane_degrade_ctrl;

    localparam logic [15:0] T = 16'd16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lane_degrade_ctrl_if bus();

    lane_degrade_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".repair_en"}, bus.o_repair_en, 0);
        chk({tag, ".done_err"}, {bus.o_done, bus.o_error}, 0);
        chk({tag, ".flags"}, {bus.o_first_8_lanes_are_functional,
                              bus.o_second_8_lanes_are_functional}, 0);
        chk({tag, ".mode"}, bus.o_width_mode, 0);
        chk({tag, ".mask"}, bus.o_lane_mask, 0);
    endtask

    // Width selection as stated: both halves -> x16, one half -> x8, none -> fail.
    function automatic logic [1:0] exp_mode(input bit f, input bit s);
        if (f && s) return 2'b00;
        if (f)      return 2'b01;
        if (s)      return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [15:0] exp_mask(input bit f, input bit s);
        return {{8{s}}, {8{f}}};
    endfunction

    // One full evaluation; delay is the RUN cycle (0-based) carrying the ack,
    // any delay >= T means no ack before the timeout.
    task automatic run_txn(input string tag, input logic [15:0] lane, input int delay,
                           input bit rf, input bit rs);
        bit lf, ls, af, as_, tmo;
        int exp_high, high;
        lf  = (lane[7:0] == 8'hFF);
        ls  = (lane[15:8] == 8'hFF);
        af  = lf && rf;
        as_ = ls && rs;
        tmo = (delay >= int'(T));
        exp_high = tmo ? int'(T) : delay + 1;

        bus.i_en = 1'b0;
        bus.i_test_ack = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_en = 1'b1;
        bus.i_lane_result = lane;
        @(negedge clk);
        chk({tag, ".rise"}, bus.o_repair_en, 1);
        high = 0;
        for (int k = 0; k < int'(T) + 4; k++) begin
            if (!bus.o_repair_en) break;
            high++;
            bus.i_lane_result     = 16'($urandom);
            bus.i_test_ack        = (k == delay);
            bus.i_remote_first_8  = (k == delay) ? rf : 1'($urandom);
            bus.i_remote_second_8 = (k == delay) ? rs : 1'($urandom);
            @(negedge clk);
        end
        bus.i_test_ack = 1'b0;
        chk({tag, ".run_len"}, high, exp_high);
        chk({tag, ".flags"}, {bus.o_first_8_lanes_are_functional,
                              bus.o_second_8_lanes_are_functional}, {lf, ls});
        if (!tmo) begin
            chk({tag, ".eval_no_done"}, bus.o_done, 0);
            @(negedge clk);
        end
        chk({tag, ".done"}, bus.o_done, 1);
        chk({tag, ".error"}, bus.o_error, tmo || !(af || as_));
        chk({tag, ".mode"}, bus.o_width_mode, tmo ? 2'b11 : exp_mode(af, as_));
        chk({tag, ".mask"}, bus.o_lane_mask, tmo ? 16'h0000 : exp_mask(af, as_));
        repeat (3) @(negedge clk);
        chk({tag, ".hold"}, {bus.o_done, bus.o_width_mode},
            {1'b1, (tmo ? 2'b11 : exp_mode(af, as_))});
        bus.i_en = 1'b0;
        @(negedge clk);
        check_idle({tag, ".idle"});
    endtask

    initial begin
        logic [15:0] lane;
        bus.i_en              = 1'b0;
        bus.i_lane_result     = 16'h0000;
        bus.i_test_ack        = 1'b0;
        bus.i_remote_first_8  = 1'b0;
        bus.i_remote_second_8 = 1'b0;

        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("x16",      16'hFFFF, 10, 1'b1, 1'b1);
        run_txn("lower_x8", 16'h00FF, 3,  1'b1, 1'b1);
        run_txn("upper_x8", 16'hFFFF, 5,  1'b0, 1'b1);
        run_txn("no_half",  16'hFEFE, 2,  1'b1, 1'b1);
        run_txn("timeout",  16'hFFFF, 99, 1'b1, 1'b1);
        run_txn("ack_last", 16'hFFFF, int'(T) - 1, 1'b1, 1'b1);
        run_txn("ack_first", 16'hFF00, 0, 1'b1, 1'b1);

        // Abort by dropping i_en in RUN
        bus.i_en = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_en = 1'b1;
        bus.i_lane_result = 16'hFFFF;
        repeat (4) @(negedge clk);
        chk("abort.in_run", bus.o_repair_en, 1);
        bus.i_en = 1'b0;
        @(negedge clk);
        check_idle("abort");

        // Reset pulse while in EVAL
        repeat (2) @(negedge clk);
        bus.i_en = 1'b1;
        bus.i_lane_result = 16'hFFFF;
        @(negedge clk);
        bus.i_test_ack = 1'b1;
        bus.i_remote_first_8 = 1'b1;
        bus.i_remote_second_8 = 1'b1;
        @(negedge clk);
        bus.i_test_ack = 1'b0;
        chk("rst_eval.in_eval", {bus.o_repair_en, bus.o_done}, 0);
        chk("rst_eval.flags", {bus.o_first_8_lanes_are_functional,
                               bus.o_second_8_lanes_are_functional}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check_idle("rst_eval.async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_eval.wait_idle", {bus.o_repair_en, bus.o_done}, 0);
        end
        bus.i_en = 1'b0;

        // Randomized evaluations
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       lane = 16'hFFFF;
                1:       lane = 16'h00FF;
                2:       lane = 16'hFF00;
                default: lane = 16'($urandom);
            endcase
            run_txn($sformatf("rand%0d", n), lane, int'($urandom_range(0, 20)),
                    1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_degrade_ctrl.md
LANE_DEGRADE_CTRL -- requirements
Module: lane_degrade_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 16'd8000, the maximum number of RUN-state cycles allowed before the repair exchange is declared failed.
REQ-002 Ports SHALL be as follows, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  level enable from MBTRAIN; requests one repair/degrade evaluation.
- i_lane_result  in  16  per-lane pass flags from the local point test; bit n = lane n passed.
- i_test_ack  in  1  completion acknowledge from the repair exchange block.
- i_remote_first_8  in  1  remote partner result for lanes 0-7.
- i_remote_second_8  in  1  remote partner result for lanes 8-15.
- o_repair_en  out  1  enable to the repair exchange block.
- o_first_8_lanes_are_functional  out  1  local result for lanes 0-7.
- o_second_8_lanes_are_functional  out  1  local result for lanes 8-15.
- o_width_mode  out  2  00 = x16, 01 = lower x8, 10 = upper x8, 11 = fail.
- o_lane_mask  out  16  active-lane mask matching o_width_mode.
- o_done  out  1  evaluation finished, whether it passed or failed.
- o_error  out  1  no usable half, or timeout.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN, EVAL, DONE and ERROR, encoded in binary.
REQ-004 In IDLE with i_en=1, the block SHALL go to RUN on the next edge and, on that same edge, latch:
- o_first_8_lanes_are_functional = AND of i_lane_result[7:0];
- o_second_8_lanes_are_functional = AND of i_lane_result[15:8].
REQ-005 o_repair_en SHALL be 1 exactly while the state is RUN, so it first rises one cycle after i_en is sampled high in IDLE.
REQ-006 The local functional flags SHALL stay constant from RUN entry until the block returns to IDLE; i_lane_result SHALL be ignored outside IDLE.
REQ-007 In RUN, a 16-bit timeout counter SHALL start at 0 on RUN entry and increment once per RUN cycle, saturating.
REQ-008 In RUN, i_test_ack=1 SHALL latch i_remote_first_8 and i_remote_second_8 and move the FSM to EVAL.
REQ-009 In RUN, if the counter equals TIMEOUT_CYCLES-1 and i_test_ack=0, the FSM SHALL move to ERROR.
REQ-010 If i_test_ack=1 arrives in the same cycle the timeout is reached, the acknowledge SHALL win and the FSM SHALL go to EVAL.
REQ-011 EVAL SHALL last one cycle and compute:
- agreed_first = local first flag AND latched remote first flag;
- agreed_second = local second flag AND latched remote second flag.
REQ-012 On leaving EVAL, the outputs SHALL be set from the agreed flags:
- both agreed: o_width_mode=00, o_lane_mask=16'hFFFF;
- first only: o_width_mode=01, o_lane_mask=16'h00FF;
- second only: o_width_mode=10, o_lane_mask=16'hFF00;
- neither: o_width_mode=11, o_lane_mask=16'h0000.
REQ-013 From EVAL the FSM SHALL go to DONE if either half is agreed, otherwise to ERROR.
REQ-014 In DONE, o_done SHALL be 1 and o_error SHALL be 0.
REQ-015 In ERROR, o_done and o_error SHALL both be 1, with o_width_mode=11 and o_lane_mask=16'h0000.
REQ-016 Latency from i_test_ack sampled high to o_done high SHALL be exactly 2 cycles.
REQ-017 DONE and ERROR SHALL be held while i_en=1; when i_en=0 the FSM SHALL go to IDLE on the next edge.
REQ-018 Deasserting i_en in RUN or EVAL SHALL abort: the FSM returns to IDLE on the next edge, o_repair_en drops at that edge, and no result is produced.
REQ-019 On every entry to IDLE, all outputs SHALL be cleared to their reset values.
REQ-020 A new evaluation SHALL require i_en to be seen low in IDLE for at least one cycle before it is seen high again.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force the state to IDLE and the counter to 0;
- drive o_repair_en, o_done and o_error to 0;
- drive both local functional flags to 0;
- drive o_width_mode to 2'b00 and o_lane_mask to 16'h0000.
REQ-022 Reset asserted mid-operation SHALL discard all latched results; after release the block SHALL wait in IDLE.

Verification
REQ-023 i_lane_result=FFFF, i_en=1, ack after 10 cycles with remote 1/1 -> o_width_mode=00, o_lane_mask=FFFF, o_done=1 two cycles after the ack, o_error=0.
REQ-024 i_lane_result=00FF, remote 1/1 -> local flags 1/0, o_width_mode=01, o_lane_mask=00FF.
REQ-025 i_lane_result=FFFF, remote first=0, second=1 -> o_width_mode=10, o_lane_mask=FF00.
REQ-026 i_lane_result=FEFE (one failing lane per half) -> o_width_mode=11, o_error=1, o_done=1.
REQ-027 TIMEOUT_CYCLES=16 with no ack -> o_repair_en high for exactly 16 cycles, then ERROR; separately, ack in the 16th cycle -> EVAL, not ERROR.
REQ-028 Two abort cases:
- i_en dropped in RUN -> IDLE next cycle, all outputs 0;
- rst_n pulsed low in EVAL -> outputs reset asynchronously, no o_done.
